// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    MULDIV = 2'd2,
    HALTED = 2'd3
  } hazard_state_t;

  // ex_regwrite value meaning "no register written"
  localparam logic [1:0] REGWRITE_NONE = 2'b00;
  // ex_muxc value selecting memory data (a load)
  localparam logic       MUXC_LOAD     = 1'b0;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Clear wins; otherwise count up and stick at all-ones.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard and stall controller for the five-stage 16-bit CPU (ID stage).
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_op1,
  input  logic [3:0]       id_op2,
  input  logic             id_uses_op2,
  input  logic             id_is_branch,
  input  logic             id_is_halt,
  input  logic             branch_taken,
  input  logic [3:0]       ex_op1,
  input  logic [1:0]       ex_regwrite,
  input  logic             ex_muxc,
  input  logic             ex_is_muldiv,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold
);

  // The entry cycle (in RUN) is itself a hold/stall cycle, so cnt holds the
  // number of extra state cycles minus one: the state lasts cnt+1 cycles.
  localparam bit         MULDIV_MULTI    = (MULDIV_LAT > 2);
  localparam logic [3:0] MULDIV_CNT_INIT = MULDIV_MULTI ? 4'(MULDIV_LAT - 3) : 4'd0;

  hazard_state_t state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  // Set on the last hold cycle so the muldiv still sitting in ID/EX during the
  // release cycle is not accepted a second time.
  logic          muldiv_done_reg, muldiv_done_next;

  logic ex_writes, ex_load, dep_op1, dep;

  // Dependence decode against the instruction currently in EX.
  always_comb begin
    ex_writes = (ex_regwrite != REGWRITE_NONE);
    ex_load   = ex_writes && (ex_muxc == MUXC_LOAD);
    dep_op1   = ex_writes && (ex_op1 == id_op1);
    dep       = dep_op1 || (ex_writes && id_uses_op2 && (ex_op1 == id_op2));
  end

  // Mealy outputs and next-state selection.
  always_comb begin
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    ex_hold          = 1'b0;
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    muldiv_done_next = 1'b0;
    if (!rst) begin
      unique case (state_reg)
        RUN: begin
          if (ex_is_muldiv && !muldiv_done_reg) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_hold     = 1'b1;
            if (MULDIV_MULTI) begin
              state_next = MULDIV;
              cnt_next   = MULDIV_CNT_INIT;
            end else begin
              muldiv_done_next = 1'b1;
            end
          end else if (id_is_branch && dep_op1) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            // A load result reaches the comparator one cycle later than an
            // ALU result, so only the load case needs an extra stall cycle.
            if (ex_load) begin
              state_next = STALL;
              cnt_next   = 4'd0;
            end
          end else if (ex_load && dep) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_is_halt) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_next  = HALTED;
          end else if (id_is_branch && branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_reg == 4'd0) state_next = RUN;
          else                 cnt_next   = cnt_reg - 4'd1;
        end
        MULDIV: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_hold     = 1'b1;
          if (cnt_reg == 4'd0) begin
            state_next       = RUN;
            muldiv_done_next = 1'b1;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
        HALTED: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      cnt_reg         <= 4'd0;
      muldiv_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      muldiv_done_reg <= muldiv_done_next;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_inc;

  // Front-end stall cycles, excluding the parked HALTED state.
  always_comb stall_inc = !pc_write && (state_reg != HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .inc (stall_inc),
    .clr (rst),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .inc (if_id_flush),
    .clr (rst),
    .q   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (MULDIV_LAT=4, CNT_W=2).
// Counter checks are included when HAZARD_PERF_EN is defined.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_op1, id_op2, ex_op1;
  logic       id_uses_op2, id_is_branch, id_is_halt, branch_taken;
  logic [1:0] ex_regwrite;
  logic       ex_muxc, ex_is_muldiv;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold;
`ifdef HAZARD_PERF_EN
  logic [1:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Expected output vectors {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold}
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_HOLD  = 5'b00001;
  localparam logic [4:0] O_HALT  = 5'b00000;
  localparam logic [4:0] O_FLUSH = 5'b11100;

  hazard_control_unit #(.MULDIV_LAT(4), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_op1       (id_op1),
    .id_op2       (id_op2),
    .id_uses_op2  (id_uses_op2),
    .id_is_branch (id_is_branch),
    .id_is_halt   (id_is_halt),
    .branch_taken (branch_taken),
    .ex_op1       (ex_op1),
    .ex_regwrite  (ex_regwrite),
    .ex_muxc      (ex_muxc),
    .ex_is_muldiv (ex_is_muldiv),
`ifdef HAZARD_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_hold      (ex_hold)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs are already set; check mid-cycle, then advance past the next edge.
  task automatic step(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    #2;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold};
    $display("step %-14s outs=%b", tag, obs);
    check(tag, {3'b000, obs}, {3'b000, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_op1 = 4'd1; id_op2 = 4'd2; id_uses_op2 = 1'b0;
    id_is_branch = 1'b0; id_is_halt = 1'b0; branch_taken = 1'b0;
    ex_op1 = 4'd9; ex_regwrite = 2'b00; ex_muxc = 1'b1; ex_is_muldiv = 1'b0;
  endtask

  task automatic ex_load_to(input logic [3:0] r);
    ex_op1 = r; ex_regwrite = 2'b01; ex_muxc = 1'b0;
  endtask

  task automatic ex_alu_to(input logic [3:0] r);
    ex_op1 = r; ex_regwrite = 2'b10; ex_muxc = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ex_load_to(4'd1);                       // would stall if reset did not win
    step("reset_outs", O_RUN);
    rst = 1'b0;
`ifdef HAZARD_PERF_EN
    check("cnt_stall_rst", {6'd0, stall_cnt}, 8'd0);
    check("cnt_flush_rst", {6'd0, flush_cnt}, 8'd0);
`endif

    // Load-use on op2
    idle(); ex_load_to(4'd3); id_op2 = 4'd3; id_uses_op2 = 1'b1;
    step("lu_stall", O_STALL);
    ex_regwrite = 2'b00;
    step("lu_resume", O_RUN);
    // op2 matches but is not read
    idle(); ex_load_to(4'd3); id_op2 = 4'd3; id_uses_op2 = 1'b0;
    step("lu_op2_unused", O_RUN);
    // Register 0 is ordinary
    idle(); ex_load_to(4'd0); id_op1 = 4'd0;
    step("lu_reg0", O_STALL);
    // ALU result feeding a non-branch: forwarding handles it
    idle(); ex_alu_to(4'd1);
    step("alu_dep_nostall", O_RUN);

    // Branch on ALU result: 1 stall, then taken -> flush for one cycle
    idle(); id_is_branch = 1'b1; id_op1 = 4'd5; ex_alu_to(4'd5);
    step("bralu_stall", O_STALL);
    ex_regwrite = 2'b00; branch_taken = 1'b1;
    step("bralu_flush", O_FLUSH);
    idle();
    step("bralu_after", O_RUN);

    // Branch on load: 2 stall cycles
    idle(); id_is_branch = 1'b1; id_op1 = 4'd5; ex_load_to(4'd5);
    step("brld_stall1", O_STALL);
    ex_regwrite = 2'b00;
    step("brld_stall2", O_STALL);
    step("brld_resume", O_RUN);

    // Muldiv: 3 hold cycles, load dependence masked, no re-acceptance
    idle(); ex_is_muldiv = 1'b1; ex_load_to(4'd3); id_op2 = 4'd3; id_uses_op2 = 1'b1;
    step("md_hold1", O_HOLD);
    step("md_hold2", O_HOLD);
    step("md_hold3", O_HOLD);
    ex_regwrite = 2'b00;                    // muldiv still presented in ID/EX
    step("md_release", O_RUN);
    idle();
    step("md_idle", O_RUN);

    // Second muldiv, reset on its 2nd cycle
    ex_is_muldiv = 1'b1;
    step("md2_hold1", O_HOLD);
    rst = 1'b1;
    step("md2_rst", O_RUN);
    rst = 1'b0; idle();
    step("md2_after_rst", O_RUN);
`ifdef HAZARD_PERF_EN
    check("cnt_stall_clr", {6'd0, stall_cnt}, 8'd0);
`endif

    // Halt, then 20 parked cycles ignoring a taken branch
    idle(); id_is_halt = 1'b1;
    step("halt_entry", O_HALT);
    idle(); id_is_branch = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 20; i++) step("halted", O_HALT);
`ifdef HAZARD_PERF_EN
    check("cnt_stall_halt", {6'd0, stall_cnt}, 8'd1);
    check("cnt_flush_halt", {6'd0, flush_cnt}, 8'd0);
`endif
    rst = 1'b1; idle();
    step("halt_rst", O_RUN);
    rst = 1'b0;
    step("halt_cleared", O_RUN);

    // Four back-to-back load-use stalls, then one flush
    idle(); ex_load_to(4'd1);
    for (int i = 0; i < 4; i++) step("lu_repeat", O_STALL);
`ifdef HAZARD_PERF_EN
    check("cnt_stall_sat", {6'd0, stall_cnt}, 8'd3);
`endif
    idle(); id_is_branch = 1'b1; branch_taken = 1'b1;
    step("flush_only", O_FLUSH);
`ifdef HAZARD_PERF_EN
    check("cnt_flush_one", {6'd0, flush_cnt}, 8'd1);
    check("cnt_stall_hold", {6'd0, stall_cnt}, 8'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
